// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   memState_t   - responder FSM encoding
//   ROM_TOP_DEF  - default highest ROM byte address
//   faultCause_t - fault cause codes, reserved for a cause register
//   CNT_W        - wait-state counter width
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } memState_t;

    typedef enum logic [1:0] {
        CAUSE_MISALIGN    = 2'd0,
        CAUSE_ROM_WRITE   = 2'd1,
        CAUSE_DUAL_STROBE = 2'd2
    } faultCause_t;

    localparam logic [15:0] ROM_TOP_DEF = 16'h0FFF;
    localparam int          CNT_W       = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: saturating wait-state counter.
//   CLK, Reset - clock, async active-high reset
//   clear      - synchronous clear to zero (wins over counting)
//   done       - count has reached MAX; counting stops there
module mem_wait_counter
    import mem_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    output logic done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (!done)
            count <= count + 1'b1;
    end

    assign done = (count == MAX[CNT_W-1:0]);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle control unit.
//   CLK, Reset          - clock, async active-high reset
//   MemRead, MemWrite   - request strobes, sampled only in IDLE
//   IorD, PC, ALUOut    - address select (1 = PC fetch, 0 = ALUOut data)
//   WriteData           - store data
//   ReadData            - last successful read result
//   MemBusy             - request in flight
//   MemReady, AddrFault - completion / fault pulses
//   FaultAddr           - address of the last faulting request
//   sram_*              - synchronous single-port SRAM interface (word addressed)
module mem_responder
    import mem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = ADDR_W'(ROM_TOP_DEF)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemBusy,
    output logic              MemReady,
    output logic              AddrFault,
    output logic [ADDR_W-1:0] FaultAddr,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    memState_t         state;
    logic              opWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic [ADDR_W-1:0] selAddr;
    logic              reqFault;
    logic              waitDone;

    assign selAddr  = IorD ? PC : ALUOut;
    assign reqFault = (MemRead && MemWrite) || selAddr[0] ||
                      (MemWrite && (selAddr <= ROM_TOP));

    // Held clear outside ACCESS so every access starts counting from zero.
    mem_wait_counter #(.MAX(WAIT_CYCLES)) u_wait (
        .CLK   (CLK),
        .Reset (Reset),
        .clear (state != ACCESS),
        .done  (waitDone)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            opWrite   <= 1'b0;
            reqAddr   <= '0;
            reqData   <= '0;
            ReadData  <= '0;
            FaultAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        opWrite <= MemWrite;
                        reqAddr <= selAddr;
                        reqData <= WriteData;
                        if (reqFault) begin
                            state     <= FAULT;
                            FaultAddr <= selAddr;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (waitDone) begin
                        if (!opWrite)
                            ReadData <= sram_rdata;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state flop alone, so a Reset drops them at once.
    assign MemBusy    = (state != IDLE);
    assign MemReady   = (state == DONE) || (state == FAULT);
    assign AddrFault  = (state == FAULT);
    assign sram_en    = (state == ACCESS);
    assign sram_we    = (state == ACCESS) && opWrite;
    assign sram_addr  = reqAddr[ADDR_W-1:1];
    assign sram_wdata = reqData;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int W = 1;

    `define CHK(tag, obs, exp) begin vectors++; assert ((obs) === (exp)) else begin miscompares++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

    logic        CLK = 1'b0, Reset = 1'b1, Reset3 = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0;
    logic [15:0] PC = '0, ALUOut = '0, WriteData = '0;

    logic [15:0] ReadData, FaultAddr, sram_wdata;
    logic [15:0] sram_rdata = '0;
    logic        MemBusy, MemReady, AddrFault, sram_en, sram_we;
    logic [14:0] sram_addr;

    logic [15:0] ReadData3, FaultAddr3, sram_wdata3;
    logic [15:0] sram_rdata3 = 16'hBEEF;
    logic        MemBusy3, MemReady3, AddrFault3, sram_en3, sram_we3;
    logic [14:0] sram_addr3;

    int vectors = 0, miscompares = 0;

    // Device-side SRAM and the bench's own transaction-level view of memory.
    logic [15:0] sram   [0:32767];
    logic [15:0] expMem [0:32767];
    logic [15:0] expRd, expFA;
    int          accessCnt = 0;
    logic        enPrev = 1'b0;

    always #5 CLK = ~CLK;

    mem_responder #(.WAIT_CYCLES(W)) dut (
        .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData), .ReadData(ReadData),
        .MemBusy(MemBusy), .MemReady(MemReady), .AddrFault(AddrFault), .FaultAddr(FaultAddr),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .CLK(CLK), .Reset(Reset3), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData), .ReadData(ReadData3),
        .MemBusy(MemBusy3), .MemReady(MemReady3), .AddrFault(AddrFault3), .FaultAddr(FaultAddr3),
        .sram_en(sram_en3), .sram_we(sram_we3), .sram_addr(sram_addr3),
        .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3)
    );

    always @(posedge CLK) begin
        if (sram_en && sram_we)  sram[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= sram[sram_addr];
        if (sram_en && !enPrev)  accessCnt <= accessCnt + 1;
        enPrev <= sram_en;
    end

    function automatic logic [15:0] pat(int w);
        return 16'(w * 40503) ^ 16'h5A5A;
    endfunction

    task automatic chkCyc(string tag, bit busy, bit rdy, bit flt, bit en, bit we);
        `CHK({tag, ".busy"}, MemBusy, busy)
        `CHK({tag, ".ready"}, MemReady, rdy)
        `CHK({tag, ".fault"}, AddrFault, flt)
        `CHK({tag, ".en"}, sram_en, en)
        `CHK({tag, ".we"}, sram_we, we)
    endtask

    // One request from IDLE at a negedge; walks every cycle to completion.
    task automatic doTxn(string tag, bit rd, bit wr, bit iord,
                         logic [15:0] pc, logic [15:0] alu, logic [15:0] wd);
        logic [15:0] a;
        bit          flt, en;
        int          rk;
        a   = iord ? pc : alu;
        flt = (rd && wr) || (a % 2 == 1) || (wr && a <= 16'h0FFF);
        rk  = flt ? 1 : W + 2;
        MemRead = rd; MemWrite = wr; IorD = iord; PC = pc; ALUOut = alu; WriteData = wd;
        @(negedge CLK);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int k = 1; k <= rk; k++) begin
            en = !flt && (k <= W + 1);
            chkCyc(tag, 1'b1, k == rk, flt && k == rk, en, en && wr);
            if (en) begin
                `CHK({tag, ".addr"}, sram_addr, 15'(a / 2))
                if (wr) `CHK({tag, ".wdata"}, sram_wdata, wd)
            end
            if (k == rk) begin
                vectors++;
                if (MemReady !== 1'b1) begin
                    miscompares++;
                    $error("FAIL %s.wait_expired: MemReady %0b not high at cycle %0d after accept",
                           tag, MemReady, k);
                end
                if (flt)      expFA = a;
                else if (!wr) expRd = expMem[a / 2];
                else          expMem[a / 2] = wd;
                `CHK({tag, ".rdata"}, ReadData, expRd)
                `CHK({tag, ".faddr"}, FaultAddr, expFA)
            end
            @(negedge CLK);
        end
        chkCyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int          cnt0, r;
        logic [15:0] a;
        bit          rd, wr, iord;

        for (int i = 0; i < 32768; i++) begin
            sram[i]   = pat(i);
            expMem[i] = pat(i);
        end
        sram[8]   = 16'hA5C3;
        expMem[8] = 16'hA5C3;
        expRd = '0;
        expFA = '0;

        repeat (2) @(negedge CLK);
        chkCyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (ReadData !== 16'h0000) begin
            miscompares++;
            $error("FAIL reset.rdata: observed %0h expected 0", ReadData);
        end
        vectors++;
        if (FaultAddr !== 16'h0000) begin
            miscompares++;
            $error("FAIL reset.faddr: observed %0h expected 0", FaultAddr);
        end
        vectors++;
        if (sram_addr !== 15'h0000) begin
            miscompares++;
            $error("FAIL reset.saddr: observed %0h expected 0", sram_addr);
        end

        // Reset mid-access on the WAIT_CYCLES=3 instance.
        Reset3 = 1'b0;
        @(negedge CLK);
        MemRead = 1'b1; IorD = 1'b1; PC = 16'h0040;
        @(negedge CLK);
        MemRead = 1'b0;
        `CHK("rst3.busy", MemBusy3, 1'b1)
        @(negedge CLK);
        `CHK("rst3.en_before", sram_en3, 1'b1)
        Reset3 = 1'b1;
        #1;
        `CHK("rst3.en_async", sram_en3, 1'b0)
        `CHK("rst3.busy_async", MemBusy3, 1'b0)
        @(negedge CLK);
        Reset3 = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            `CHK("rst3.noready", MemReady3, 1'b0)
            `CHK("rst3.idle", MemBusy3, 1'b0)
        end
        `CHK("rst3.rdata", ReadData3, 16'h0000)

        Reset = 1'b0;
        @(negedge CLK);

        // Directed cases.
        doTxn("fetch",    1, 0, 1, 16'h0010, 16'h0000, 16'h0000);
        doTxn("dwrite",   0, 1, 0, 16'h0000, 16'h2000, 16'h1234);
        cnt0 = accessCnt;
        doTxn("romwr",    0, 1, 0, 16'h0000, 16'h0100, 16'hDEAD);
        doTxn("misalign", 1, 0, 0, 16'h0000, 16'h2001, 16'h0000);
        doTxn("dual",     1, 1, 0, 16'h0000, 16'h3000, 16'h7777);
        doTxn("romtop",   0, 1, 0, 16'h0000, 16'h0FFE, 16'h4444);
        `CHK("fault.noaccess", accessCnt - cnt0, 0)
        doTxn("readback", 1, 0, 0, 16'h0000, 16'h2000, 16'h0000);
        doTxn("ramlow",   0, 1, 0, 16'h0000, 16'h1000, 16'hCAFE);
        doTxn("topwr",    0, 1, 0, 16'h0000, 16'hFFFE, 16'hBEEF);
        doTxn("toprd",    1, 0, 1, 16'hFFFE, 16'h0000, 16'h0000);
        doTxn("lowrd",    1, 0, 0, 16'h0000, 16'h1000, 16'h0000);

        // Strobe raised during ACCESS: ignored until IDLE, then served.
        cnt0 = accessCnt;
        IorD = 1'b1; PC = 16'h0010; MemRead = 1'b1;
        @(negedge CLK);
        MemRead = 1'b0;
        chkCyc("b2b.k1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        PC = 16'h2000;
        @(negedge CLK);
        chkCyc("b2b.k2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        `CHK("b2b.k2.addr", sram_addr, 15'h0008)
        MemRead = 1'b1;
        @(negedge CLK);
        chkCyc("b2b.k3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expRd = expMem[8];
        `CHK("b2b.k3.rdata", ReadData, expRd)
        @(negedge CLK);
        chkCyc("b2b.k4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        MemRead = 1'b0;
        chkCyc("b2b.k5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        `CHK("b2b.k5.addr", sram_addr, 15'h1000)
        @(negedge CLK);
        chkCyc("b2b.k6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        chkCyc("b2b.k7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expRd = expMem[16'h1000];
        `CHK("b2b.k7.rdata", ReadData, expRd)
        @(negedge CLK);
        chkCyc("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        `CHK("b2b.accesses", accessCnt - cnt0, 2)

        // Randomized requests against the transaction-level model.
        for (int t = 0; t < 60; t++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r <= 5);
            wr = (r == 0) || (r > 5);
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 16'h0FFF));
            else                           a = 16'($urandom_range(16'h1000, 16'hFFFF));
            a[0] = ($urandom_range(0, 7) == 0);
            iord = 1'($urandom_range(0, 1));
            doTxn("rand", rd, wr, iord, iord ? a : 16'($urandom), iord ? 16'($urandom) : a,
                  16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
